// File: rtl/dout_pack.sv
// Serializer for the square-root result: captures root/remainder on a calcend rise
// and streams them as {tag, flag, payload} words into the output FIFO under back-pressure.
module dout_pack #(
    parameter int VW = 128,
    parameter int RW = 129,
    parameter int DW = 48,
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          calcend,
    input  logic [VW-1:0] vout,
    input  logic [RW-1:0] rout,
    input  logic          rem_en,
    input  logic          full,
    output logic [DW-1:0] dataout,
    output logic          wren,
    output logic          busy,
    output logic          done,
    output logic          overrun
);
    localparam int PW  = DW - TW - 1;
    localparam int NV  = (VW + PW - 1) / PW;
    localparam int NR  = (RW + PW - 1) / PW;
    localparam int VPW = NV * PW;
    localparam int RPW = NR * PW;

    generate
        if (PW < 1 || NV + NR > (1 << TW) - 1) begin : g_bad_params
            $error("dout_pack: tag space too small for NV+NR beats, or no payload bits");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SEND_V, SEND_R} state_t;

    state_t          state;
    logic            calcend_d;
    logic            rem_q;
    logic [TW-1:0]   beat;
    logic [VPW-1:0]  vsh;
    logic [RPW-1:0]  rsh;
    logic            rise;

    assign rise = calcend & ~calcend_d;

    // Shadow registers hold left-justified operands; each issued beat shifts the next slice to the top.
    always_ff @(posedge clk) begin
        if (state == IDLE && rise) begin
            vsh <= VPW'(vout) << (VPW - VW);
            rsh <= RPW'(rout) << (RPW - RW);
        end else if (state == SEND_V && !full) begin
            vsh <= vsh << PW;
        end else if (state == SEND_R && !full) begin
            rsh <= rsh << PW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            calcend_d <= 1'b0;
            rem_q     <= 1'b0;
            beat      <= '0;
            dataout   <= '0;
            wren      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            calcend_d <= calcend;
            wren      <= 1'b0;
            done      <= 1'b0;
            if (rise && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (rise) begin
                        rem_q <= rem_en;
                        beat  <= '0;
                        busy  <= 1'b1;
                        state <= SEND_V;
                    end
                end
                SEND_V: begin
                    if (!full) begin
                        wren    <= 1'b1;
                        dataout <= {beat + TW'(1), 1'b0, vsh[VPW-1 -: PW]};
                        if (beat == TW'(NV - 1)) begin
                            beat <= '0;
                            if (rem_q) begin
                                state <= SEND_R;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            beat <= beat + TW'(1);
                        end
                    end
                end
                SEND_R: begin
                    if (!full) begin
                        wren    <= 1'b1;
                        dataout <= {beat + TW'(NV + 1), 1'b1, rsh[RPW-1 -: PW]};
                        if (beat == TW'(NR - 1)) begin
                            beat  <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            beat <= beat + TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
